// File: rtl/mcu_pkg.sv
// Shared opcodes, idle bus word, dispatcher state encoding and fault codes
// for the fetch/dispatch sequencer and its execution units.
package mcu_pkg;

   localparam logic [3:0]  OPC_MOV   = 4'b0110;
   localparam logic [3:0]  OPC_HALT  = 4'hF;
   localparam logic [15:0] IDLE_WORD = 16'hF000;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LATCH,
      S_EXEC,
      S_FLUSH,
      S_HALT,
      S_FAULT
   } disp_state_t;

   typedef enum logic [1:0] {
      FC_NONE    = 2'b00,
      FC_ILLEGAL = 2'b01,
      FC_TIMEOUT = 2'b10
   } fault_code_t;

endpackage

// File: rtl/instr_dispatch_fsm_if.sv
// Instruction-memory and execution-unit bus between the dispatcher (master)
// and the memory / exec FSM bank (slave).
interface instr_dispatch_fsm_if #(
   parameter int PC_W      = 8,
   parameter int NUM_UNITS = 16
);
   logic [PC_W-1:0]      imem_addr;
   logic                 imem_rd;
   logic [15:0]          imem_data;
   logic [15:0]          fullBitNum;
   logic [NUM_UNITS-1:0] done_vec;
   logic [NUM_UNITS-1:0] pc_inc_vec;

   modport master (
      output imem_addr, imem_rd, fullBitNum,
      input  imem_data, done_vec, pc_inc_vec
   );

   modport slave (
      input  imem_addr, imem_rd, fullBitNum,
      output imem_data, done_vec, pc_inc_vec
   );
endinterface

// File: rtl/opc_onehot_dec.sv
// 4-bit opcode to one-hot unit select.
module opc_onehot_dec #(
   parameter int N = 16
) (
   input  logic [3:0]   opc,
   output logic [N-1:0] onehot
);
   assign onehot = N'(1) << opc;
endmodule

// File: rtl/instr_dispatch_fsm.sv
// Fetch/latch/execute/flush sequencer: owns PC, broadcasts IR to the exec
// FSM bank, waits for the selected unit's done, and tracks halt/fault status.
module instr_dispatch_fsm
   import mcu_pkg::*;
#(
   parameter int                   PC_W      = 8,
   parameter int                   NUM_UNITS = 16,
   parameter logic [NUM_UNITS-1:0] IMPL_MASK = NUM_UNITS'(1) << OPC_MOV,
   parameter int                   TIMEOUT   = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 run,
   instr_dispatch_fsm_if.master bus,
   output logic [PC_W-1:0]      pc,
   output logic                 busy,
   output logic                 halted,
   output logic                 fault,
   output logic [1:0]           fault_code,
   output logic [15:0]          instr_count
);

   disp_state_t          state, nxt;
   logic [15:0]          ir;
   logic [7:0]           tmo_cnt;
   logic                 imem_rd_q;
   logic [3:0]           dec_opc;
   logic [NUM_UNITS-1:0] opc_oh;
   logic                 sel_done, sel_inc, impl, tmo_hit;

   // One decoder serves both the legality check (fresh word in LATCH) and
   // the done/pc_inc select (latched IR in EXEC).
   assign dec_opc = (state == S_LATCH) ? bus.imem_data[15:12] : ir[15:12];

   opc_onehot_dec #(.N(NUM_UNITS)) u_dec (
      .opc    (dec_opc),
      .onehot (opc_oh)
   );

   assign sel_done = |(bus.done_vec & opc_oh);
   assign sel_inc  = |(bus.pc_inc_vec & opc_oh);
   assign impl     = |(IMPL_MASK & opc_oh);
   assign tmo_hit  = (tmo_cnt == 8'(TIMEOUT - 1));

   assign bus.imem_addr  = pc;
   assign bus.imem_rd    = imem_rd_q;
   assign bus.fullBitNum = (state == S_EXEC) ? ir : IDLE_WORD;

   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:  if (run) nxt = S_FETCH;
         S_FETCH: nxt = S_LATCH;
         S_LATCH: begin
            if (bus.imem_data[15:12] == OPC_HALT) nxt = S_HALT;
            else if (!impl)                       nxt = S_FAULT;
            else                                  nxt = S_EXEC;
         end
         S_EXEC: begin
            if (sel_done)     nxt = S_FLUSH;
            else if (tmo_hit) nxt = S_FAULT;
         end
         S_FLUSH: nxt = run ? S_FETCH : S_IDLE;
         S_HALT:  nxt = S_HALT;
         S_FAULT: nxt = S_FAULT;
         default: nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         pc          <= '0;
         ir          <= IDLE_WORD;
         imem_rd_q   <= 1'b0;
         busy        <= 1'b0;
         halted      <= 1'b0;
         fault       <= 1'b0;
         fault_code  <= FC_NONE;
         instr_count <= '0;
         tmo_cnt     <= '0;
      end else begin
         state     <= nxt;
         // Status flags track the state being entered so they line up with it.
         imem_rd_q <= (nxt == S_FETCH);
         busy      <= nxt inside {S_FETCH, S_LATCH, S_EXEC, S_FLUSH};
         halted    <= (nxt == S_HALT);
         fault     <= (nxt == S_FAULT);
         case (state)
            S_LATCH: begin
               ir      <= bus.imem_data;
               tmo_cnt <= '0;
               if (nxt == S_FAULT) fault_code <= FC_ILLEGAL;
            end
            S_EXEC: begin
               if (sel_inc) pc <= pc + 1'b1;
               if (sel_done)     instr_count <= instr_count + 16'd1;
               else if (tmo_hit) fault_code  <= FC_TIMEOUT;
               else              tmo_cnt     <= tmo_cnt + 8'd1;
            end
            default: ;
         endcase
      end
   end

endmodule
